// File: rtl/swd_target_responder.sv
// SWD target (DP-side responder): decodes host requests, returns ACK/read data and captures write data.
// Latency: every output update lands SYNC_STAGES+1 clk after the SWCLK rise that caused it.
// Backpressure: none at the pin level; WAIT/FAULT are returned to the host as supplied on ack_code.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   swclk, swdio_i      asynchronous SWD pins from the host, oversampled in clk
//   swdio_o, swdio_oe   SWDIO drive value and drive enable
//   ack_code, rdata     response for the current request (sampled at the end of the first turnaround)
//   req_valid, req_*    decoded-request pulse and latched APnDP / RnW / A[3:2]
//   wr_valid, wdata     write-data pulse and captured write word
//   line_reset, par_err line-reset pulse and sticky parity error flag
// Optional feature: define SWD_PARITY_CHECK_EN to enforce request and write-data parity.
module swd_target_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TRN_CYCLES  = 1,
  parameter int LRST_ONES   = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swclk,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic [2:0]  ack_code,
  input  logic [31:0] rdata,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr,
  output logic        wr_valid,
  output logic [31:0] wdata,
  output logic        line_reset,
  output logic        par_err
);

  localparam int            OW        = $clog2(LRST_ONES + 1);
  localparam logic [OW-1:0] ONES_SAT  = OW'(LRST_ONES);
  localparam logic [OW-1:0] ONES_LAST = OW'(LRST_ONES - 1);
  localparam logic [5:0]    TRN_LAST  = 6'(TRN_CYCLES - 1);
  localparam logic [2:0]    ACK_OK    = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_TRN1,
    ST_ACK,
    ST_RDATA,
    ST_TRN2W,
    ST_WDATA,
    ST_TRN2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. swclk and swdio use the same depth so the data sampled
  // on a detected rise is the value that was on the pin at that SWCLK edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] swclk_sync;
  logic [SYNC_STAGES-1:0] swdio_sync;
  logic                   swclk_prev;
  logic                   rise;
  logic                   din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swclk_sync <= '0;
      swdio_sync <= '0;
      swclk_prev <= 1'b0;
    end else begin
      swclk_sync <= {swclk_sync[SYNC_STAGES-2:0], swclk};
      swdio_sync <= {swdio_sync[SYNC_STAGES-2:0], swdio_i};
      swclk_prev <= swclk_sync[SYNC_STAGES-1];
    end
  end

  assign rise = swclk_sync[SYNC_STAGES-1] & ~swclk_prev;
  assign din  = swdio_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;        // bit / turnaround counter, shared by all phases
  logic [5:0]    req_sh_q, req_sh_d;  // first six request bits after start, LSB-first
  logic [31:0]   wsh_q, wsh_d;        // write data shift register
  logic [31:0]   rd_q, rd_d;          // read data snapshot for this request
  logic [2:0]    ack_q, ack_d;        // ACK snapshot for this request
  logic [OW-1:0] ones_q, ones_d;      // consecutive host-driven 1s, saturating
  logic          need_zero_q, need_zero_d;

  logic          o_d, oe_d;
  logic          req_valid_d, wr_valid_d, line_reset_d;
  logic          apndp_d, rnw_d;
  logic [1:0]    addr_d;
  logic [31:0]   wdata_d;
  logic          par_err_d;

  logic          host_phase;
  logic          lrst_hit;
  logic          req_frame_ok;  // Stop==0 and Park==1 on the final request bit
  logic          req_par_ok;

  // Phases in which the host owns SWDIO; only these feed the line-reset counter.
  assign host_phase = (state_q == ST_IDLE)  || (state_q == ST_REQ) ||
                      (state_q == ST_TRN2W) || (state_q == ST_WDATA);

  assign lrst_hit     = rise && host_phase && din && (ones_q == ONES_LAST);
  assign req_frame_ok = ~req_sh_q[5] & din;

`ifdef SWD_PARITY_CHECK_EN
  assign req_par_ok = ~(^req_sh_q[4:0]);
`else
  assign req_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_sh_q    <= '0;
      wsh_q       <= '0;
      rd_q        <= '0;
      ack_q       <= '0;
      ones_q      <= '0;
      need_zero_q <= 1'b0;
      swdio_o     <= 1'b0;
      swdio_oe    <= 1'b0;
      req_valid   <= 1'b0;
      req_apndp   <= 1'b0;
      req_rnw     <= 1'b0;
      req_addr    <= '0;
      wr_valid    <= 1'b0;
      wdata       <= '0;
      line_reset  <= 1'b0;
      par_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_sh_q    <= req_sh_d;
      wsh_q       <= wsh_d;
      rd_q        <= rd_d;
      ack_q       <= ack_d;
      ones_q      <= ones_d;
      need_zero_q <= need_zero_d;
      swdio_o     <= o_d;
      swdio_oe    <= oe_d;
      req_valid   <= req_valid_d;
      req_apndp   <= apndp_d;
      req_rnw     <= rnw_d;
      req_addr    <= addr_d;
      wr_valid    <= wr_valid_d;
      wdata       <= wdata_d;
      line_reset  <= line_reset_d;
      par_err     <= par_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_sh_d     = req_sh_q;
    wsh_d        = wsh_q;
    rd_d         = rd_q;
    ack_d        = ack_q;
    ones_d       = ones_q;
    need_zero_d  = need_zero_q;
    o_d          = swdio_o;
    oe_d         = swdio_oe;
    req_valid_d  = 1'b0;
    wr_valid_d   = 1'b0;
    line_reset_d = 1'b0;
    apndp_d      = req_apndp;
    rnw_d        = req_rnw;
    addr_d       = req_addr;
    wdata_d      = wdata;
    par_err_d    = par_err;

    if (rise) begin
      // Ones counter: target-driven bits break the run.
      if (host_phase && din) begin
        if (ones_q != ONES_SAT) ones_d = ones_q + OW'(1);
      end else begin
        ones_d = '0;
      end
      if (!din) need_zero_d = 1'b0;

      if (lrst_hit) begin
        // Line reset overrides whatever bit this rise would otherwise complete.
        state_d      = ST_IDLE;
        cnt_d        = '0;
        oe_d         = 1'b0;
        o_d          = 1'b0;
        line_reset_d = 1'b1;
        par_err_d    = 1'b0;
        need_zero_d  = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (din && !need_zero_q) begin
              state_d = ST_REQ;
              cnt_d   = '0;
            end
          end

          ST_REQ: begin
            req_sh_d = {din, req_sh_q[5:1]};
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd6) begin
              // din is Park; req_sh_q holds APnDP,RnW,A2,A3,Parity,Stop at [0..5].
              cnt_d = '0;
              if (req_frame_ok && req_par_ok) begin
                req_valid_d = 1'b1;
                apndp_d     = req_sh_q[0];
                rnw_d       = req_sh_q[1];
                addr_d      = req_sh_q[3:2];
                state_d     = ST_TRN1;
              end else begin
                if (req_frame_ok) par_err_d = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end

          ST_TRN1: begin
            if (cnt_q == TRN_LAST) begin
              ack_d   = ack_code;
              rd_d    = rdata;
              oe_d    = 1'b1;
              o_d     = ack_code[0];
              cnt_d   = '0;
              state_d = ST_ACK;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end

          ST_ACK: begin
            cnt_d = cnt_q + 6'd1;
            case (cnt_q)
              6'd0: o_d = ack_q[1];
              6'd1: o_d = ack_q[2];
              default: begin
                // Third rise: the host has just sampled ack[2]. Either start
                // the read data immediately or release the line.
                if (ack_q == ACK_OK && req_rnw) begin
                  o_d     = rd_q[0];
                  cnt_d   = 6'd1;
                  state_d = ST_RDATA;
                end else begin
                  oe_d    = 1'b0;
                  o_d     = 1'b0;
                  cnt_d   = '0;
                  state_d = (ack_q == ACK_OK) ? ST_TRN2W : ST_TRN2;
                end
              end
            endcase
          end

          ST_RDATA: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q < 6'd32) begin
              o_d = rd_q[cnt_q[4:0]];
            end else if (cnt_q == 6'd32) begin
              o_d = ^rd_q;
            end else begin
              oe_d    = 1'b0;
              o_d     = 1'b0;
              cnt_d   = '0;
              state_d = ST_TRN2;
            end
          end

          ST_TRN2W: begin
            if (cnt_q == TRN_LAST) begin
              cnt_d   = '0;
              state_d = ST_WDATA;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end

          ST_WDATA: begin
            if (cnt_q == 6'd32) begin
              // din is the write parity bit.
              cnt_d   = '0;
              state_d = ST_IDLE;
`ifdef SWD_PARITY_CHECK_EN
              if ((^wsh_q) == din) begin
                wdata_d    = wsh_q;
                wr_valid_d = 1'b1;
              end else begin
                par_err_d = 1'b1;
              end
`else
              wdata_d    = wsh_q;
              wr_valid_d = 1'b1;
`endif
            end else begin
              wsh_d = {din, wsh_q[31:1]};
              cnt_d = cnt_q + 6'd1;
            end
          end

          ST_TRN2: begin
            if (cnt_q == TRN_LAST) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end

          default: begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            o_d     = 1'b0;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swd_target_responder.sv
// Bench for swd_target_responder: a behavioural SWD host drives requests, turnarounds and
// data bit by bit; expected ACK/data/pulses come from a transaction-level model.
// Define SWD_PARITY_CHECK_EN for both files to exercise the parity-enforcing build.
`timescale 1ns/1ps
module tb_swd_target_responder;

  localparam int TRN = 1;
`ifdef SWD_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        swclk;
  logic        swdio_i;
  logic        swdio_o;
  logic        swdio_oe;
  logic [2:0]  ack_code;
  logic [31:0] rdata;
  logic        req_valid;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic        wr_valid;
  logic [31:0] wdata;
  logic        line_reset;
  logic        par_err;

  swd_target_responder #(
    .SYNC_STAGES(2),
    .TRN_CYCLES (TRN),
    .LRST_ONES  (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .swclk     (swclk),
    .swdio_i   (swdio_i),
    .swdio_o   (swdio_o),
    .swdio_oe  (swdio_oe),
    .ack_code  (ack_code),
    .rdata     (rdata),
    .req_valid (req_valid),
    .req_apndp (req_apndp),
    .req_rnw   (req_rnw),
    .req_addr  (req_addr),
    .wr_valid  (wr_valid),
    .wdata     (wdata),
    .line_reset(line_reset),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitors, sampled on the inactive clock edge.
  int req_cnt = 0;
  int wr_cnt = 0;
  int lr_cnt = 0;
  int overlap_cnt = 0;
  int oe_hi_cnt = 0;
  always @(negedge clk) begin
    if (req_valid) req_cnt++;
    if (wr_valid) wr_cnt++;
    if (line_reset) lr_cnt++;
    if (req_valid && wr_valid) overlap_cnt++;
    if (swdio_oe) oe_hi_cnt++;
  end

  // Reference model state
  logic [31:0] exp_wdata;
  logic        exp_par_err;

  logic [2:0] ack_tab [8] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b111};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SWCLK period: drive d while low, sample what the target drove at the
  // previous rise, then raise SWCLK. Period 80 ns = 8 clk.
  task automatic host_bit(input logic d, output logic so, output logic soe);
    swdio_i = d;
    #35;
    so  = swdio_o;
    soe = swdio_oe;
    #5 swclk = 1'b1;
    #40 swclk = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    logic so, soe;
    repeat (n) host_bit(1'b0, so, soe);
  endtask

  function automatic logic [7:0] mk_req(input logic apndp, input logic rnw,
                                        input logic [1:0] a, input logic bad);
    logic p;
    p = apndp ^ rnw ^ a[0] ^ a[1] ^ bad;
    return {1'b1, 1'b0, p, a[1], a[0], rnw, apndp, 1'b1};
  endfunction

  task automatic line_rst(input int n);
    int lc0, oe0;
    logic so, soe;
    lc0 = lr_cnt;
    oe0 = oe_hi_cnt;
    repeat (n) host_bit(1'b1, so, soe);
    idle_bits(2);
    exp_par_err = 1'b0;
    check("lrst_pulses", lr_cnt - lc0, 1);
    check("lrst_oe", oe_hi_cnt - oe0, 0);
    check("lrst_par_err", par_err, exp_par_err);
  endtask

  task automatic xfer(input logic [7:0] req, input logic [2:0] ack, input logic [31:0] rd,
                      input logic [31:0] wd, input logic wbad, input int abort_bit);
    logic so, soe, oe_all, gpar, apndp, rnw, par_ok, ok;
    logic [1:0]  a;
    logic [2:0]  gack;
    logic [31:0] got;
    int rc0, wc0, oe0;
    apndp  = req[1];
    rnw    = req[2];
    a      = req[4:3];
    par_ok = ($countones(req[5:1]) % 2) == 0;
    ok     = (ack == 3'b001);
    ack_code = ack;
    rdata    = rd;
    rc0 = req_cnt;
    wc0 = wr_cnt;
    gack = '0;
    got  = '0;
    gpar = 1'b0;
    idle_bits(2);
    for (int i = 0; i < 8; i++) host_bit(req[i], so, soe);

    if (PCHK && !par_ok) begin
      oe0 = oe_hi_cnt;
      idle_bits(8);
      exp_par_err = 1'b1;
      check("bad_req_no_valid", req_cnt - rc0, 0);
      check("bad_req_silent", oe_hi_cnt - oe0, 0);
      check("bad_req_par_err", par_err, exp_par_err);
      return;
    end

    repeat (TRN) begin
      host_bit(1'b0, so, soe);
      check("trn1_oe", soe, 1'b0);
    end
    oe_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_bit(1'b0, so, soe);
      gack[i] = so;
      oe_all  = oe_all & soe;
    end
    check("ack_bits", gack, ack);
    check("ack_oe", oe_all, 1'b1);
    check("req_valid_cnt", req_cnt - rc0, 1);
    check("req_fields", {req_apndp, req_rnw, req_addr}, {apndp, rnw, a});

    if (ok && rnw) begin
      for (int i = 0; i < 33; i++) begin
        host_bit(1'b0, so, soe);
        if (i < 32) got[i] = so;
        else gpar = so;
        oe_all = oe_all & soe;
        if (i == abort_bit) begin
          reset = 1'b1;
          #10;
          check("abort_oe", swdio_oe, 1'b0);
          check("abort_outs", {swdio_o, req_valid, req_apndp, req_rnw, req_addr,
                               wr_valid, line_reset, par_err, wdata}, '0);
          reset = 1'b0;
          #10;
          exp_wdata   = '0;
          exp_par_err = 1'b0;
          idle_bits(2);
          check("abort_no_wr", wr_cnt - wc0, 0);
          check("abort_req_cnt", req_cnt - rc0, 1);
          return;
        end
      end
      check("rdata", got, rd);
      check("rdata_par", gpar, ^rd);
      check("rdata_oe", oe_all, 1'b1);
      host_bit(1'b0, so, soe);
      check("rd_release_oe", soe, 1'b0);
      idle_bits(TRN);
    end else if (ok) begin
      host_bit(1'b0, so, soe);
      check("wr_release_oe", soe, 1'b0);
      idle_bits(TRN - 1);
      for (int i = 0; i < 32; i++) host_bit(wd[i], so, soe);
      host_bit((^wd) ^ wbad, so, soe);
      idle_bits(2);
      if (PCHK && wbad) begin
        exp_par_err = 1'b1;
        check("wr_valid_cnt", wr_cnt - wc0, 0);
      end else begin
        exp_wdata = wd;
        check("wr_valid_cnt", wr_cnt - wc0, 1);
      end
      check("wdata", wdata, exp_wdata);
    end else begin
      host_bit(1'b0, so, soe);
      check("nodata_release_oe", soe, 1'b0);
      oe0 = oe_hi_cnt;
      idle_bits(TRN + 3);
      check("nodata_silent", oe_hi_cnt - oe0, 0);
      check("nodata_no_wr", wr_cnt - wc0, 0);
    end
    check("par_err", par_err, exp_par_err);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run did not end by 800000 ns");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    reset    = 1'b1;
    swclk    = 1'b0;
    swdio_i  = 1'b0;
    ack_code = 3'b000;
    rdata    = '0;
    exp_wdata   = '0;
    exp_par_err = 1'b0;

    #20;
    check("reset_outs", {swdio_o, swdio_oe, req_valid, req_apndp, req_rnw, req_addr,
                         wr_valid, line_reset, par_err}, '0);
    check("reset_wdata", wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Line reset from power-up
    line_rst(56);

    // DP read A=0 with OK
    xfer(8'hA5, 3'b001, 32'h2BA01477, 32'h0, 1'b0, -1);
    // DP write A=0 with OK
    xfer(8'h81, 3'b001, 32'h0, 32'h12345678, 1'b0, -1);
    check("wdata_directed", wdata, 32'h12345678);
    // WAIT on a read, FAULT and an out-of-set code on writes
    xfer(8'hA5, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, -1);
    xfer(8'h81, 3'b100, 32'h0, 32'hCAFEF00D, 1'b0, -1);
    xfer(8'h81, 3'b111, 32'h0, 32'h0BADF00D, 1'b0, -1);
    check("wdata_kept", wdata, 32'h12345678);

    // Bad request parity: ignored in the default build, rejected otherwise
    xfer(8'hB5, 3'b001, 32'h5A5A0FF0, 32'h0, 1'b0, -1);
    if (PCHK) line_rst(50);

    // Reset while the target is driving read data bit 10, then a clean read
    xfer(8'hA5, 3'b001, 32'hFFFF0000, 32'h0, 1'b0, 10);
    xfer(8'hA5, 3'b001, 32'h2BA01477, 32'h0, 1'b0, -1);

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      r = mk_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      xfer(r, ack_tab[$urandom_range(0, 7)], $urandom, $urandom,
           $urandom_range(0, 5) == 0, -1);
      if (n % 8 == 7) line_rst(50 + $urandom_range(0, 10));
    end

    check("no_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
